// File: rtl/script_executor.sv
// ============================================================================
//  Module   : script_executor
//  Purpose  : Fetches 16-bit kitchen-script instructions and plays them out as
//             UART command bytes, gated by game feedback status.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module script_executor #(
    parameter logic [15:0] WAIT_TIMEOUT = 16'd65535,
    parameter logic [15:0] DELAY_UNIT   = 16'd1536
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        script_mode,
    input  logic [15:0] script,
    input  logic [7:0]  dataOut_bits,
    input  logic        dataOut_valid,
    input  logic        dataIn_ready,
    output logic [7:0]  pc,
    output logic [7:0]  dataIn_bits,
    output logic        running,
    output logic        done,
    output logic        error,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_SEND      = 4'd3,
        S_WAIT_COND = 4'd4,
        S_DELAY     = 4'd5,
        S_HALT      = 4'd6,
        S_ERROR     = 4'd7
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  data_q, data_d;
    logic [5:0]  status_q, status_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  tick_q, tick_d;
    logic        run_q;

    logic [2:0]  opcode;
    logic [2:0]  func;
    logic [7:0]  imm;
    logic        cond;
    logic        advance;
    logic        run_rise;
    logic        run_fall;
    logic        unused_bits;

    assign opcode      = script[2:0];
    assign func        = script[7:5];
    assign imm         = script[15:8];
    assign unused_bits = ^script[4:3];
    assign run_rise    = run & ~run_q;
    assign run_fall    = ~run & run_q;

    // Feedback is visible to WAIT/JIF in the same cycle it arrives.
    always_comb begin
        status_d = status_q;
        if (dataOut_valid && dataOut_bits[1:0] == 2'b01) begin
            status_d = dataOut_bits[7:2];
        end
    end

    assign cond = status_d[func[1:0]] ^ func[2];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        tick_d  = tick_q;
        advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_rise) begin
                    pc_d    = 8'd0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                cnt_d  = 16'd0;
                tick_d = 8'd0;
                case (opcode)
                    3'd0: begin
                        if (func >= 3'd1 && func <= 3'd5) begin
                            data_d  = {3'b000, func, 2'b10};
                            state_d = S_SEND;
                        end else begin
                            state_d = S_ERROR;
                        end
                    end
                    3'd1: begin
                        data_d  = {imm[5:0], 2'b11};
                        state_d = S_SEND;
                    end
                    3'd2: state_d = S_WAIT_COND;
                    3'd3: begin
                        if (cond) begin
                            pc_d    = imm;
                            state_d = S_FETCH;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                    3'd4: begin
                        if (func == 3'd1 || func == 3'd2) begin
                            data_d  = {4'd0, func[1:0], 2'b01};
                            state_d = S_SEND;
                        end else begin
                            state_d = S_ERROR;
                        end
                    end
                    3'd5: state_d = S_HALT;
                    3'd6: begin
                        if (imm == 8'd0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = S_DELAY;
                        end
                    end
                    default: state_d = S_ERROR;
                endcase
            end
            S_SEND: begin
                if (dataIn_ready) begin
                    data_d  = 8'd0;
                    advance = 1'b1;
                end
            end
            S_WAIT_COND: begin
                if (cond) begin
                    advance = 1'b1;
                end else if (cnt_q == WAIT_TIMEOUT - 16'd1) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DELAY: begin
                // Unit counter times one tick; tick counter counts ticks up to imm.
                if (cnt_q == DELAY_UNIT - 16'd1) begin
                    cnt_d = 16'd0;
                    if ({1'b0, tick_q} + 9'd1 == {1'b0, imm}) begin
                        advance = 1'b1;
                    end else begin
                        tick_d = tick_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: ;
        endcase

        if (advance) begin
            if (pc_q == 8'hFF) begin
                state_d = S_ERROR;
            end else begin
                pc_d    = pc_q + 8'd1;
                state_d = S_FETCH;
            end
        end

        if (run_fall) begin
            state_d = S_IDLE;
            data_d  = 8'd0;
            pc_d    = pc_q;
        end

        if (script_mode) begin
            state_d = S_IDLE;
            data_d  = 8'd0;
            pc_d    = 8'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= 8'd0;
            data_q   <= 8'd0;
            status_q <= 6'd0;
            cnt_q    <= 16'd0;
            tick_q   <= 8'd0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            data_q   <= data_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            run_q    <= run;
        end
    end

    assign pc          = pc_q;
    assign dataIn_bits = data_q;
    assign running     = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERROR);
    assign done        = (state_q == S_HALT);
    assign error       = (state_q == S_ERROR);
    assign state_dbg   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_script_executor.sv
// ============================================================================
//  Module   : tb_script_executor
//  Purpose  : Scoreboard bench for script_executor with a one-cycle script RAM.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_script_executor;

    logic        clk;
    logic        rst;
    logic        run;
    logic        script_mode;
    logic [15:0] script;
    logic [7:0]  dataOut_bits;
    logic        dataOut_valid;
    logic        dataIn_ready;
    logic [7:0]  pc;
    logic [7:0]  dataIn_bits;
    logic        running;
    logic        done;
    logic        error;
    logic [3:0]  state_dbg;

    logic [15:0] mem [256];
    logic [7:0]  exp_q [$];
    int          n_checks;
    int          n_fail;

    script_executor #(
        .WAIT_TIMEOUT(16'd50),
        .DELAY_UNIT  (16'd4)
    ) u_dut (
        .clock        (clk),
        .reset        (rst),
        .run          (run),
        .script_mode  (script_mode),
        .script       (script),
        .dataOut_bits (dataOut_bits),
        .dataOut_valid(dataOut_valid),
        .dataIn_ready (dataIn_ready),
        .pc           (pc),
        .dataIn_bits  (dataIn_bits),
        .running      (running),
        .done         (done),
        .error        (error),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) script <= mem[pc];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_byte(input string tag);
        int k;
        logic [7:0] exp;
        k = 0;
        while (dataIn_bits == 8'd0 && k < 200) begin
            tick(1);
            k++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
        check_eq({tag, "_byte"}, {24'd0, dataIn_bits}, {24'd0, exp});
    endtask

    task automatic serve_byte(input string tag);
        logic [7:0] held;
        wait_byte(tag);
        held = dataIn_bits;
        tick(20);
        check_eq({tag, "_hold"}, {24'd0, dataIn_bits}, {24'd0, held});
        dataIn_ready = 1'b1;
        tick(1);
        dataIn_ready = 1'b0;
        check_eq({tag, "_clear"}, {24'd0, dataIn_bits}, 32'd0);
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while (!(done || error) && k < 500) begin
            tick(1);
            k++;
        end
        check_eq({tag, "_end"}, {31'd0, done | error}, 32'd1);
    endtask

    task automatic stop_run(input string tag);
        run = 1'b0;
        tick(2);
        check_eq({tag, "_idle"}, {29'd0, done, error, running}, 32'd0);
    endtask

    task automatic feed(input logic [7:0] b);
        dataOut_bits  = b;
        dataOut_valid = 1'b1;
        tick(1);
        dataOut_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        run           = 1'b0;
        script_mode   = 1'b0;
        dataOut_bits  = 8'd0;
        dataOut_valid = 1'b0;
        dataIn_ready  = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0005;
        tick(3);
        check_eq("rst_pc", {24'd0, pc}, 32'd0);
        check_eq("rst_data", {24'd0, dataIn_bits}, 32'd0);
        check_eq("rst_flags", {29'd0, running, done, error}, 32'd0);
        rst = 1'b0;
        tick(2);

        // SEL 5; ACT get; END
        mem[0] = 16'h0501; mem[1] = 16'h0020; mem[2] = 16'h0005;
        exp_q.push_back(8'h17);
        exp_q.push_back(8'h06);
        run = 1'b1;
        serve_byte("sel");
        serve_byte("act");
        wait_end("t1");
        check_eq("t1_done", {31'd0, done}, 32'd1);
        check_eq("t1_pc", {24'd0, pc}, 32'd2);
        stop_run("t1");

        // GAME end; END
        mem[0] = 16'h0044; mem[1] = 16'h0005;
        exp_q.push_back(8'h09);
        run = 1'b1;
        serve_byte("game");
        wait_end("t2");
        check_eq("t2_pc", {24'd0, pc}, 32'd1);
        stop_run("t2");

        // WAIT player ready, satisfied by feedback arriving mid-wait
        mem[0] = 16'h0002;
        run = 1'b1;
        tick(30);
        check_eq("wait_stall_pc", {24'd0, pc}, 32'd0);
        check_eq("wait_running", {31'd0, running}, 32'd1);
        feed(8'h05);
        check_eq("wait_same_cycle_pc", {24'd0, pc}, 32'd1);
        wait_end("t3");
        check_eq("t3_done", {31'd0, done}, 32'd1);
        stop_run("t3");

        // Clear status while idle; a non-status byte must not touch it
        feed(8'h01);
        feed(8'h06);
        run = 1'b1;
        tick(52);
        check_eq("timeout_early", {31'd0, error}, 32'd0);
        tick(1);
        check_eq("timeout_err", {31'd0, error}, 32'd1);
        check_eq("timeout_pc", {24'd0, pc}, 32'd0);
        stop_run("t4");

        // JIF on status bit1, taken then inverted
        feed(8'h09);
        mem[0] = 16'h1023;
        run = 1'b1;
        wait_end("jif_t");
        check_eq("jif_taken_pc", {24'd0, pc}, 32'h10);
        check_eq("jif_taken_done", {31'd0, done}, 32'd1);
        stop_run("jif_t");
        mem[0] = 16'h10A3;
        run = 1'b1;
        wait_end("jif_n");
        check_eq("jif_not_pc", {24'd0, pc}, 32'd1);
        stop_run("jif_n");

        // DELAY 3 ticks of 4 cycles, then DELAY 0
        mem[0] = 16'h0306; mem[1] = 16'h0006; mem[2] = 16'h0005;
        run = 1'b1;
        tick(14);
        check_eq("delay_stall_pc", {24'd0, pc}, 32'd0);
        check_eq("delay_running", {31'd0, running}, 32'd1);
        tick(1);
        check_eq("delay_end_pc", {24'd0, pc}, 32'd1);
        tick(2);
        check_eq("delay0_pc", {24'd0, pc}, 32'd2);
        wait_end("t6");
        stop_run("t6");

        // script_mode abort during SEND; stray ready afterwards
        mem[0] = 16'h0006; mem[1] = 16'h2A01;
        exp_q.push_back(8'hAB);
        run = 1'b1;
        wait_byte("abort");
        check_eq("abort_pre_pc", {24'd0, pc}, 32'd1);
        script_mode = 1'b1;
        tick(1);
        script_mode = 1'b0;
        check_eq("abort_state", {24'd0, pc, dataIn_bits, 7'd0, running}, 32'd0);
        dataIn_ready = 1'b1;
        tick(1);
        dataIn_ready = 1'b0;
        tick(3);
        check_eq("abort_stray_ready", {24'd0, pc, dataIn_bits, 7'd0, running}, 32'd0);
        run = 1'b0;
        tick(2);

        // Asynchronous reset in the middle of SEND
        mem[0] = 16'h2A01;
        exp_q.push_back(8'hAB);
        run = 1'b1;
        wait_byte("arst");
        rst = 1'b1;
        #1;
        check_eq("arst_data", {24'd0, dataIn_bits}, 32'd0);
        check_eq("arst_running", {31'd0, running}, 32'd0);
        tick(1);
        rst = 1'b0;
        run = 1'b0;
        tick(2);

        // Illegal opcode at pc 3, recovery by run toggle
        mem[0] = 16'h0006; mem[1] = 16'h0006; mem[2] = 16'h0006; mem[3] = 16'h0007;
        run = 1'b1;
        wait_end("ill");
        check_eq("ill_err", {30'd0, error, done}, 32'd2);
        check_eq("ill_pc", {24'd0, pc}, 32'd3);
        run = 1'b0;
        tick(1);
        check_eq("ill_clear", {31'd0, error}, 32'd0);
        check_eq("ill_pc_kept", {24'd0, pc}, 32'd3);
        run = 1'b1;
        tick(1);
        check_eq("restart_pc", {24'd0, pc}, 32'd0);
        check_eq("restart_running", {31'd0, running}, 32'd1);
        tick(10);
        run = 1'b0;
        tick(2);

        check_eq("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
